// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-cycle instruction memory handshake, IF/ID register.
// Latency: 1 cycle from an accepted request (o_imem_req && i_imem_ready) to the word appearing in IF/ID.
// Backpressure: i_stall freezes PC, IF/ID, state and counter; i_imem_ready=0 holds the address and loads a bubble.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_stall              hazard stall from decode/hazard unit
//   i_pcsrc, i_nextPC    PC select (00 seq, 01/11 redirect to i_nextPC, 10 exception vector)
//   o_imem_addr/o_imem_req, i_imem_rdata/i_imem_ready   instruction memory request/response
//   o_pc, o_instr, o_valid                              IF/ID register (o_pc is PC+4 of held instr)
//   o_ifetch_err         PC misaligned, fetching suppressed until redirect/exception
//   o_fetch_cnt          number of instructions accepted into IF/ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic [31:0] i_nextPC,
    input  logic [1:0]  i_pcsrc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_ifetch_err,
    output logic [31:0] o_fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        ERR   = 2'b10
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Registered state
    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_instr_q;
    logic        ifid_valid_q;
    logic [31:0] fetch_cnt_q;

    // Next-state values
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] ifid_pc_nxt;
    logic [31:0] ifid_instr_nxt;
    logic        ifid_valid_nxt;
    logic [31:0] fetch_cnt_nxt;

    // Decoded controls
    logic        take_exc;
    logic        take_redir;
    logic [31:0] pc_plus4;
    logic        redir_misaligned;

    // Exception is 10; redirect is any select with bit 0 set (01 or 11).
    assign take_exc         = (i_pcsrc == 2'b10);
    assign take_redir       = i_pcsrc[0];
    // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0.
    assign pc_plus4         = pc_q + 32'd4;
    assign redir_misaligned = (i_nextPC[1:0] != 2'b00);

    // Memory request is purely combinational so a stall drops it in the same cycle.
    assign o_imem_addr  = pc_q;
    assign o_imem_req   = (state_q == FETCH) && !i_stall;
    assign o_ifetch_err = (state_q == ERR);

    assign o_pc        = ifid_pc_q;
    assign o_instr     = ifid_instr_q;
    assign o_valid     = ifid_valid_q;
    assign o_fetch_cnt = fetch_cnt_q;

    // Next-state and datapath selection. Priority below reset:
    // exception > stall > redirect > sequential. A bubble clears the
    // instruction and valid but leaves o_pc as it was.
    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        ifid_pc_nxt    = ifid_pc_q;
        ifid_instr_nxt = ifid_instr_q;
        ifid_valid_nxt = ifid_valid_q;
        fetch_cnt_nxt  = fetch_cnt_q;

        if (take_exc) begin
            // Wins over stall; any word returned this cycle is dropped.
            state_nxt      = FETCH;
            pc_nxt         = EXC_VECTOR;
            ifid_instr_nxt = NOP;
            ifid_valid_nxt = 1'b0;
        end else if (i_stall) begin
            // Everything holds (defaults).
            state_nxt = state_q;
        end else if (take_redir) begin
            // Same-cycle fetch is discarded; a misaligned target parks in ERR.
            state_nxt      = redir_misaligned ? ERR : FETCH;
            pc_nxt         = i_nextPC;
            ifid_instr_nxt = NOP;
            ifid_valid_nxt = 1'b0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    // One idle cycle after reset release before the first request.
                    state_nxt      = FETCH;
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end
                FETCH: begin
                    if (i_imem_ready) begin
                        ifid_instr_nxt = i_imem_rdata;
                        ifid_pc_nxt    = pc_plus4;
                        ifid_valid_nxt = 1'b1;
                        pc_nxt         = pc_plus4;
                        fetch_cnt_nxt  = fetch_cnt_q + 32'd1;
                    end else begin
                        // Wait state: address held stable, bubble into decode.
                        ifid_instr_nxt = NOP;
                        ifid_valid_nxt = 1'b0;
                    end
                end
                ERR: begin
                    // Parked: no requests, PC held, only redirect/exception leave.
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end
                default: begin
                    // Unreachable encoding; recover through BOOT.
                    state_nxt      = BOOT;
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'h0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            ifid_pc_q    <= ifid_pc_nxt;
            ifid_instr_q <= ifid_instr_nxt;
            ifid_valid_q <= ifid_valid_nxt;
            fetch_cnt_q  <= fetch_cnt_nxt;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter EXC_VECTOR, 32'h8000_0180, PC value loaded on exception redirect.
REQ-003 SHALL provide port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port i_stall  input  1  hazard stall from decode/hazard unit.
REQ-006 SHALL provide port i_nextPC  input  32  redirect target computed by decode.
REQ-007 SHALL provide port i_pcsrc  input  2  PC select: 00 sequential, 01/11 i_nextPC, 10 EXC_VECTOR.
REQ-008 SHALL provide port o_imem_addr  output  32  instruction memory address, equal to PC register.
REQ-009 SHALL provide port o_imem_req  output  1  instruction memory request.
REQ-010 SHALL provide port i_imem_rdata  input  32  instruction word, valid when i_imem_ready=1.
REQ-011 SHALL provide port i_imem_ready  input  1  same-cycle completion of the current request.
REQ-012 SHALL provide port o_pc  output  32  PC+4 of the instruction held in IF/ID (decode i_pc).
REQ-013 SHALL provide port o_instr  output  32  IF/ID instruction word.
REQ-014 SHALL provide port o_valid  output  1  IF/ID holds a real instruction.
REQ-015 SHALL provide port o_ifetch_err  output  1  PC misaligned, fetch suppressed.
REQ-016 SHALL provide port o_fetch_cnt  output  32  count of instructions accepted into IF/ID.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, ERR.
REQ-018 SHALL drive o_imem_req = (state==FETCH) && !i_stall, combinationally.
REQ-019 SHALL define a bubble as o_instr=32'h0 (NOP), o_valid=0, o_pc unchanged.
REQ-020 SHALL apply per-cycle priority: reset > exception (i_pcsrc=10) > i_stall > redirect (01/11) > sequential (00).
REQ-021 Exception SHALL, even when i_stall=1: PC<=EXC_VECTOR, IF/ID<=bubble, state<=FETCH; any same-cycle fetch is discarded and not counted.
REQ-022 Stall SHALL hold PC, IF/ID, state and o_fetch_cnt unchanged.
REQ-023 Redirect SHALL: PC<=i_nextPC, IF/ID<=bubble, same-cycle fetch discarded and not counted; state<=ERR if i_nextPC[1:0]!=0, else FETCH.
REQ-024 Sequential in FETCH with i_imem_ready=1 SHALL: o_instr<=i_imem_rdata, o_pc<=PC+4, o_valid<=1, PC<=PC+4, o_fetch_cnt+1; latency 1 cycle, request to IF/ID.
REQ-025 Sequential in FETCH with i_imem_ready=0 SHALL load a bubble and hold PC (wait state, address stable).
REQ-026 BOOT SHALL last exactly one cycle after reset release: no request, IF/ID bubble, then FETCH.
REQ-027 ERR SHALL keep o_ifetch_err=1, o_imem_req=0, IF/ID bubble, PC held; it exits only via exception or redirect.
REQ-028 o_ifetch_err SHALL equal (state==ERR); it is cleared in the same edge as the exiting redirect/exception.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0); o_fetch_cnt SHALL wrap modulo 2^32.

Reset
REQ-030 On i_rst_n=0 at a rising edge: PC=RESET_PC, state=BOOT, o_instr=0, o_pc=0, o_valid=0, o_ifetch_err=0, o_fetch_cnt=0; this overrides all other inputs, including mid-wait and mid-stall.

Verification
REQ-031 Reset release, ready tied 1, rdata=A,B,C -> req low 1 cycle; then addr 0,4,8; o_instr A,B,C with o_pc 4,8,12; o_fetch_cnt 1,2,3.
REQ-032 i_stall=1 for 3 cycles while o_instr=B -> req=0; o_instr, o_pc, PC and count frozen; resume fetches addr 8.
REQ-033 Redirect pcsrc=01, i_nextPC=0x100, ready=1 -> next cycle o_valid=0, instr not counted, addr=0x100; the following fetch gives o_pc=0x104.
REQ-034 Exception pcsrc=10 with i_stall=1 -> addr=0x80000180 next cycle, bubble; then redirect to 0x102 -> o_ifetch_err=1, req=0 until redirect to 0x200 clears it.
REQ-035 Ready low 2 cycles at addr 0x20 -> two bubbles, addr held at 0x20; PC=0xFFFFFFFC fetch -> o_pc=0, next addr=0.
